// File: rtl/switch_debouncer.sv
// Per-bit switch conditioner: multi-flop synchroniser, stability-counter debounce,
// registered clean level plus one-cycle rise/fall pulses and an aggregate change flag.
module switch_debouncer #(
  parameter int unsigned WIDTH         = 4,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 500000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] switch_in,
  output logic [WIDTH-1:0] switch_level,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             changed
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  sync_s;

  logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]            level_q, level_d;
  logic [WIDTH-1:0]            rise_q, rise_d;
  logic [WIDTH-1:0]            fall_q, fall_d;
  logic                        changed_q, changed_d;

  // Stage 0 captures the raw pin; the highest stage is the metastability-safe copy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], switch_in};
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      // Any return to the current level leaves cnt_d at its zero default.
      if (sync_s[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          level_d[i] = sync_s[i];
          rise_d[i]  = sync_s[i];
          fall_d[i]  = ~sync_s[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    changed_d = |{rise_d, fall_d};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      level_q   <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
    end
  end

  assign switch_level = level_q;
  assign rise_pulse   = rise_q;
  assign fall_pulse   = fall_q;
  assign changed      = changed_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with SYNC_STAGES=2, STABLE_CYCLES=4:
// level changes land on the 6th edge after the input settles.
module tb_switch_debouncer;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] switch_in;
  logic [3:0] switch_level;
  logic [3:0] rise_pulse;
  logic [3:0] fall_pulse;
  logic       changed;

  int checks = 0;
  int errors = 0;

  switch_debouncer #(
    .WIDTH        (4),
    .SYNC_STAGES  (2),
    .STABLE_CYCLES(4)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .switch_in   (switch_in),
    .switch_level(switch_level),
    .rise_pulse  (rise_pulse),
    .fall_pulse  (fall_pulse),
    .changed     (changed)
  );

  always #5 clock = ~clock;

  // Advance one rising edge and settle 1 ns past it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    switch_in = 4'b1111;
    for (int e = 1; e <= 4; e++) begin
      step();
      checks++;
      if ({switch_level, rise_pulse, fall_pulse, changed} !== 13'b0) begin
        errors++;
        $display("FAIL reset e%0d: got %b expected %b", e,
                 {switch_level, rise_pulse, fall_pulse, changed}, 13'b0);
      end
    end
  endtask

  task automatic test_release();
    logic [12:0] exp_v;
    reset     = 1'b0;
    switch_in = 4'b0110;
    for (int e = 1; e <= 8; e++) begin
      step();
      exp_v = (e == 6) ? {4'b0110, 4'b0110, 4'b0000, 1'b1} :
              (e > 6)  ? {4'b0110, 4'b0000, 4'b0000, 1'b0} : 13'b0;
      checks++;
      if ({switch_level, rise_pulse, fall_pulse, changed} !== exp_v) begin
        errors++;
        $display("FAIL release e%0d: got %b expected %b", e,
                 {switch_level, rise_pulse, fall_pulse, changed}, exp_v);
      end
    end
  endtask

  task automatic test_glitch();
    logic [12:0] exp_v;
    switch_in = 4'b0111;
    for (int e = 1; e <= 9; e++) begin
      step();
      if (e == 3) switch_in = 4'b0110;
      checks++;
      if ({switch_level, rise_pulse, fall_pulse, changed} !== {4'b0110, 9'b0}) begin
        errors++;
        $display("FAIL glitch e%0d: got %b expected %b", e,
                 {switch_level, rise_pulse, fall_pulse, changed}, {4'b0110, 9'b0});
      end
    end
    switch_in = 4'b0111;
    for (int e = 1; e <= 7; e++) begin
      step();
      exp_v = (e == 6) ? {4'b0111, 4'b0001, 4'b0000, 1'b1} :
              (e > 6)  ? {4'b0111, 9'b0} : {4'b0110, 9'b0};
      checks++;
      if ({switch_level, rise_pulse, fall_pulse, changed} !== exp_v) begin
        errors++;
        $display("FAIL glitch_hold e%0d: got %b expected %b", e,
                 {switch_level, rise_pulse, fall_pulse, changed}, exp_v);
      end
    end
  endtask

  task automatic test_bounce();
    logic [12:0] exp_v;
    for (int i = 0; i < 20; i++) begin
      switch_in = {((i / 2) % 2 == 0), 3'b111};
      step();
      checks++;
      if ({switch_level, rise_pulse, fall_pulse, changed} !== {4'b0111, 9'b0}) begin
        errors++;
        $display("FAIL bounce i%0d: got %b expected %b", i,
                 {switch_level, rise_pulse, fall_pulse, changed}, {4'b0111, 9'b0});
      end
    end
    switch_in = 4'b1111;
    for (int e = 1; e <= 9; e++) begin
      step();
      exp_v = (e == 6) ? {4'b1111, 4'b1000, 4'b0000, 1'b1} :
              (e > 6)  ? {4'b1111, 9'b0} : {4'b0111, 9'b0};
      checks++;
      if ({switch_level, rise_pulse, fall_pulse, changed} !== exp_v) begin
        errors++;
        $display("FAIL bounce_hold e%0d: got %b expected %b", e,
                 {switch_level, rise_pulse, fall_pulse, changed}, exp_v);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [12:0] exp_v;
    switch_in = 4'b1011;
    for (int e = 1; e <= 7; e++) begin
      step();
      exp_v = (e == 6) ? {4'b1011, 4'b0000, 4'b0100, 1'b1} :
              (e > 6)  ? {4'b1011, 9'b0} : {4'b1111, 9'b0};
      checks++;
      if ({switch_level, rise_pulse, fall_pulse, changed} !== exp_v) begin
        errors++;
        $display("FAIL fall_prep e%0d: got %b expected %b", e,
                 {switch_level, rise_pulse, fall_pulse, changed}, exp_v);
      end
    end
    switch_in = 4'b1110;
    for (int e = 1; e <= 8; e++) begin
      step();
      exp_v = (e == 6) ? {4'b1110, 4'b0100, 4'b0001, 1'b1} :
              (e > 6)  ? {4'b1110, 9'b0} : {4'b1011, 9'b0};
      checks++;
      if ({switch_level, rise_pulse, fall_pulse, changed} !== exp_v) begin
        errors++;
        $display("FAIL simultaneous e%0d: got %b expected %b", e,
                 {switch_level, rise_pulse, fall_pulse, changed}, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid_count();
    logic [12:0] exp_v;
    switch_in = 4'b1111;
    for (int e = 1; e <= 3; e++) begin
      step();
      checks++;
      if ({switch_level, rise_pulse, fall_pulse, changed} !== {4'b1110, 9'b0}) begin
        errors++;
        $display("FAIL pending e%0d: got %b expected %b", e,
                 {switch_level, rise_pulse, fall_pulse, changed}, {4'b1110, 9'b0});
      end
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({switch_level, rise_pulse, fall_pulse, changed} !== 13'b0) begin
      errors++;
      $display("FAIL async_reset: got %b expected %b",
               {switch_level, rise_pulse, fall_pulse, changed}, 13'b0);
    end
    for (int e = 1; e <= 2; e++) begin
      step();
      checks++;
      if ({switch_level, rise_pulse, fall_pulse, changed} !== 13'b0) begin
        errors++;
        $display("FAIL reset_hold e%0d: got %b expected %b", e,
                 {switch_level, rise_pulse, fall_pulse, changed}, 13'b0);
      end
    end
    reset = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      step();
      exp_v = (e == 6) ? {4'b1111, 4'b1111, 4'b0000, 1'b1} :
              (e > 6)  ? {4'b1111, 9'b0} : 13'b0;
      checks++;
      if ({switch_level, rise_pulse, fall_pulse, changed} !== exp_v) begin
        errors++;
        $display("FAIL post_reset e%0d: got %b expected %b", e,
                 {switch_level, rise_pulse, fall_pulse, changed}, exp_v);
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    switch_in = 4'b0000;
    test_reset();
    test_release();
    test_glitch();
    test_bounce();
    test_simultaneous();
    test_reset_mid_count();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
